// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample width, default FIR latency, sample type, small helpers.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package fir_pkg;

    localparam int DW          = 16;
    localparam int LAT_DEFAULT = 2;

    typedef logic signed [DW-1:0] sample_t;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Saturating increment for 8-bit event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fir_result_sink_if.sv
// Bundle of FIR capture inputs, reader handshake and status for fir_result_sink.
// Latency: n/a (wires only).
// Backpressure: out_vld/out_rdy on the read side; the capture side cannot be stalled.
interface fir_result_sink_if #(
    parameter int DW    = fir_pkg::DW,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          x_vld;
    logic [DW-1:0] y;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          out_rdy;
    logic [CW-1:0] count;
    logic          full;
    logic          ovf;
    logic [7:0]    drop_cnt;

    // The sink block itself.
    modport slave (
        input  x_vld, y, flush, out_rdy,
        output out_data, out_vld, count, full, ovf, drop_cnt
    );

    // The upstream FIR / downstream reader side.
    modport master (
        output x_vld, y, flush, out_rdy,
        input  out_data, out_vld, count, full, ovf, drop_cnt
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, DEPTH x DW, with occupancy count and full flag.
// Latency: a push is visible at rd_data one cycle after the write edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module sync_fifo #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is deliberately unreset; only pointers and count carry state.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; count is kept separately so full and empty are unambiguous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/fir_result_sink.sv
// Tags FIR input samples, delays the tag by the FIR latency and captures the matching y into a FIFO.
// Latency: x_vld at edge k -> capture at edge k+LAT -> out_vld visible after that edge.
// Backpressure: reader stalls via out_rdy; captures arriving while full are dropped and counted.
module fir_result_sink
    import fir_pkg::*;
#(
    parameter int DW    = fir_pkg::DW,
    parameter int LAT   = fir_pkg::LAT_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    fir_result_sink_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [LAT-1:0] tag;
    logic           capture;
    logic           push;
    logic           pop;
    logic           drop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [DW-1:0]  fifo_rd_data;
    logic           ovf_q;
    logic [7:0]     drop_cnt_q;

    // Tag pipe mirrors the FIR latency; the oldest bit marks the edge at which y is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag <= '0;
        end else if (bus.flush) begin
            tag <= '0;
        end else begin
            tag <= (tag << 1) | LAT'(bus.x_vld);
        end
    end

    assign capture = tag[LAT-1];

    // Flush wins over any capture or pop in the same cycle.
    assign pop  = !bus.flush && !fifo_empty && bus.out_rdy;
    assign push = !bus.flush && capture && (!fifo_full || pop);
    assign drop = !bus.flush && capture && fifo_full && !pop;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.flush),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.y),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Overflow is sticky until flush/reset; the drop counter saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (bus.flush) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q      <= 1'b1;
            drop_cnt_q <= sat_inc8(drop_cnt_q);
        end
    end

    assign bus.out_data = fifo_rd_data;
    assign bus.out_vld  = !fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.full     = fifo_full;
    assign bus.ovf      = ovf_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fir_result_sink.sv
// Directed and random checks of fir_result_sink against a queue-based reference model.
// Latency: model captures y LAT edges after each x_vld.
// Backpressure: reader readiness driven directly by the bench.
module tb_fir_result_sink;
    import fir_pkg::*;

    localparam int TDW    = 16;
    localparam int TLAT   = 2;
    localparam int TDEPTH = 8;

    logic clk;
    logic rst;

    fir_result_sink_if #(.DW(TDW), .DEPTH(TDEPTH)) bus ();

    fir_result_sink #(
        .DW    (TDW),
        .LAT   (TLAT),
        .DEPTH (TDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queued entries, edge numbers at which captures are due, status.
    logic [TDW-1:0] mq[$];
    int             due[$];
    int             cyc = 0;
    bit             m_ovf = 1'b0;
    int             m_drop = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        due.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_all();
        chk("out_vld", 32'(bus.out_vld), 32'(mq.size() != 0));
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("full", 32'(bus.full), 32'(mq.size() == TDEPTH));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        if (mq.size() != 0) begin
            chk("out_data", 32'(bus.out_data), 32'(mq[0]));
        end
    endtask

    // Apply inputs for one edge, advance the model by that edge, then check outputs.
    task automatic step(input bit xv, input logic [TDW-1:0] yv, input bit rdy, input bit fl);
        bit cap;
        bit popm;
        bus.x_vld   = xv;
        bus.y       = yv;
        bus.out_rdy = rdy;
        bus.flush   = fl;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            cap = (due.size() != 0) && (due[0] == cyc);
            if (cap) void'(due.pop_front());
            popm = (mq.size() != 0) && rdy;
            if (popm) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < TDEPTH) begin
                    mq.push_back(yv);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (xv) due.push_back(cyc + TLAT);
        end
        cyc++;
        #1;
        check_all();
    endtask

    sample_t        svals[6];
    logic [TDW-1:0] first_val;
    logic [TDW-1:0] yy;

    initial begin
        bus.x_vld   = 1'b0;
        bus.y       = '0;
        bus.out_rdy = 1'b0;
        bus.flush   = 1'b0;
        rst         = 1'b0;
        svals = '{16'sd44, 16'sd7, -16'sd143, 16'sd2, 16'sd124, 16'sd112};

        // Reset state
        #12;
        check_all();
        rst = 1'b1;

        // Latency: single tag, y valid only at edge 2
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        step(1'b0, 16'hDEAD, 1'b0, 1'b0);
        chk("lat_early_vld", 32'(bus.out_vld), 32'd0);
        step(1'b0, 16'd44, 1'b0, 1'b0);
        chk("lat_vld", 32'(bus.out_vld), 32'd1);
        chk("lat_data", 32'(bus.out_data), 32'd44);
        step(1'b0, 16'hDEAD, 1'b1, 1'b0);
        chk("lat_pop_vld", 32'(bus.out_vld), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'hDEAD, 1'b1, 1'b0);

        // Stream with reader always ready
        for (int i = 0; i < 6 + TLAT + 1; i++) begin
            yy = (i >= TLAT && i - TLAT < 6) ? TDW'(svals[i - TLAT]) : 16'hDEAD;
            step(i < 6, yy, 1'b1, 1'b0);
            n_assert++;
            assert (bus.count <= 1) else begin
                n_fail++;
                $error("FAIL stream_count: observed %0d expected <=1", bus.count);
            end
        end
        chk("stream_ovf", 32'(bus.ovf), 32'd0);

        // Overflow: 10 captures into an 8-deep FIFO with no reader
        for (int i = 0; i < 10 + TLAT; i++) begin
            yy = 16'($urandom);
            if (i == TLAT) first_val = yy;
            step(i < 10, yy, 1'b0, 1'b0);
        end
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_flag", 32'(bus.ovf), 32'd1);
        chk("ovf_drops", 32'(bus.drop_cnt), 32'd2);
        chk("ovf_head", 32'(bus.out_data), 32'(first_val));
        for (int i = 0; i < 9; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(bus.out_vld), 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Full with simultaneous capture and pop, then drop-counter saturation
        for (int i = 0; i < 8 + TLAT; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        chk("fullpp_fill", 32'(bus.count), 32'd8);
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
        chk("fullpp_count", 32'(bus.count), 32'd8);
        chk("fullpp_drops", 32'(bus.drop_cnt), 32'd0);
        for (int i = 0; i < 300; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        chk("sat_drops", 32'(bus.drop_cnt), 32'd255);
        for (int i = 0; i < 12; i++) step(1'b0, 16'($urandom), 1'b1, 1'b0);

        // Flush with count=5 and two tags in flight
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5 + TLAT; i++) step(i < 5, 16'($urandom), 1'b0, 1'b0);
        chk("flush_pre_count", 32'(bus.count), 32'd5);
        step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b0, 16'h1234, 1'b0, 1'b1);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < TLAT + 1; i++) begin
            step(1'b0, 16'h5678, 1'b0, 1'b0);
            chk("flush_no_capture", 32'(bus.out_vld), 32'd0);
        end

        // Async reset mid-operation with count=3
        for (int i = 0; i < 3 + TLAT; i++) step(i < 3, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 1'b0, 1'b0);
        chk("rst_pre_count", 32'(bus.count), 32'd3);
        bus.x_vld = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        chk("rst_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_drops", 32'(bus.drop_cnt), 32'd0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < TLAT + 2; i++) step(1'b0, 16'hBEEF, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) != 0, 16'($urandom), ($urandom % 4) == 0 ? 1'b0 : ($urandom % 2) == 0,
                 ($urandom % 64) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_result_sink.md
# fir_result_sink

Capture block on the output side of the 3-tap FIR datapath. The FIR's `y` has no valid qualifier, so this block tags each input sample as it enters the FIR, delays the tag by the FIR latency, and uses it to capture the matching `y` into a small show-ahead FIFO. A downstream reader drains the FIFO with a valid/ready handshake. Overflow is reported, never silently hidden.

## Interface
- `DW`, 16 — width of FIR output `y` and of stored entries
- `LAT`, 2 — FIR latency in cycles, from `x` sampled to matching `y` valid; legal range 1..8
- `DEPTH`, 8 — FIFO entries; power of two, ≥2
- `clk`  in  1  — single clock, all state on rising edge
- `rst`  in  1  — reset, asynchronous and active-low
- `x_vld`  in  1  — a sample is presented to the FIR `x` input this cycle
- `y`  in  DW  — FIR output, signed two's complement
- `flush`  in  1  — synchronous clear of FIFO, tag pipe, status
- `out_data`  out  DW  — FIFO head; valid only when `out_vld`=1
- `out_vld`  out  1  — FIFO non-empty
- `out_rdy`  in  1  — reader accepts head this cycle
- `count`  out  $clog2(DEPTH+1)  — current occupancy
- `full`  out  1  — `count`==DEPTH
- `ovf`  out  1  — sticky: at least one capture dropped
- `drop_cnt`  out  8  — dropped-capture count, saturates at 255

## Operation
- Tag pipe: LAT-bit shift register. `tag[0]` <= `x_vld`; `tag[i]` <= `tag[i-1]`. A capture occurs on an edge where `tag[LAT-1]`=1; `y` is sampled at that edge.
- Pop: `out_vld && out_rdy` at the edge. Pop advances `rd_ptr`.
- Push: capture && (!full || pop). Push writes `y` at `wr_ptr` and advances `wr_ptr`.
- Simultaneous push and pop when full: both occur, `count` stays at DEPTH, no drop.
- Simultaneous push and pop when empty: no pop (`out_vld`=0); the push occurs.
- Drop: capture && full && !pop. On a drop, `ovf` <= 1 and `drop_cnt` <= min(`drop_cnt`+1, 255).
- Pointers are $clog2(DEPTH) bits and wrap naturally. `count` is held as a separate register: +1 on push only, −1 on pop only.
- Stored data passes through unmodified. No sign handling; DW bits in, DW bits out.
- Flush (sync, priority over everything): clears `tag`, pointers, `count`, `ovf`, `drop_cnt`. In-flight tags are discarded. A capture or pop in the same cycle is ignored.
- Async reset gives the same state as flush. Reset mid-stream loses all queued and in-flight data.
- No state machine beyond the FIFO. `full`, `out_vld` and `out_data` are combinational from registers: `out_data` = `mem[rd_ptr]`.

## Timing
- Reset values: `out_vld`=0, `count`=0, `full`=0, `ovf`=0, `drop_cnt`=0. `out_data` is don't-care; the memory is not reset.
- `x_vld` high at edge k → capture at edge k+LAT → `out_vld`=1 after edge k+LAT. Minimum latency from sample to visible output is LAT cycles.
- Back-to-back `x_vld` yields one capture per cycle. With `out_rdy` held 1, throughput is 1/cycle and `count` ≤1.
- `out_data` is stable while `out_vld`=1 and `out_rdy`=0.
- `ovf`/`drop_cnt` update at the edge of the dropping capture.

## Structure
- Shared package `fir_pkg`: `DW`, default `LAT`, and typedef `sample_t` (signed [DW-1:0]). The FIR top and this block both use it.
- One sub-module is natural: `sync_fifo` (show-ahead, DEPTH×DW, push/pop/count/full). The tag pipe, drop logic and status registers stay in `fir_result_sink`.

## Test plan
- Reset: assert `rst`=0 mid-operation with `count`=3 → immediately `out_vld`=0, `count`=0, `ovf`=0, `drop_cnt`=0.
- Latency: `x_vld` pulse at edge 0; drive `y`=16'd44 at edge 2, other cycles `y`=16'hDEAD → after edge 2, `out_vld`=1, `out_data`=44. Pop → `out_vld`=0. Nothing else is captured.
- Stream: `x_vld`=1 for 6 cycles; `y` sequence 44, 7, −143, 2, 124, 112 from LAT onward; `out_rdy`=1 → same 6 values out in order, `count` never >1, `ovf`=0.
- Overflow: 10 consecutive captures, `out_rdy`=0 → `count`=8, `full`=1, `ovf`=1, `drop_cnt`=2, `out_data`=first value. Draining yields the first 8 values in order.
- Full push+pop: at `count`=8 with capture and `out_rdy`=1 in the same cycle → `count`=8, `drop_cnt` unchanged, new value at the tail. Repeat 300 drops → `drop_cnt`=255 (saturated).
- Flush: `flush`=1 while 2 tags are in flight and `count`=5 → next cycle `count`=0, `ovf`=0, and no captures in the following LAT cycles.
